// File: rtl/seq_int_divider_if.sv
// Initiator/responder handshake for the multicycle integer divider:
// operand strobes from the ALU, results and ready back from the divider.
interface seq_int_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_ope;
  logic             write_a;
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;
  logic             ready;

  modport master (
    output a, b, signed_ope, write_a, start, flush,
    input  quotient, remainder, dbz, ready
  );

  modport slave (
    input  a, b, signed_ope, write_a, start, flush,
    output quotient, remainder, dbz, ready
  );
endinterface

// File: rtl/seq_int_divider.sv
// Radix-2 restoring divider, signed/unsigned, fixed latency WIDTH+2 cycles.
// Operands are reduced to magnitudes in PREP and the signs re-applied in FIX.
module seq_int_divider #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  seq_int_divider_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] dividend_q, divisor_q;
  logic             signed_q;
  logic [WIDTH-1:0] b_mag_q;
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] qsh_q;
  logic             q_sign_q, r_sign_q, dbz_flag_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dbz_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign a_neg = signed_q & dividend_q[WIDTH-1];
  assign b_neg = signed_q & divisor_q[WIDTH-1];
  assign a_mag = a_neg ? -dividend_q : dividend_q;
  assign b_mag = b_neg ? -divisor_q  : divisor_q;

  // qsh_q starts as the dividend magnitude and fills with quotient bits from
  // the right, so its MSB is always the next dividend bit to bring down.
  assign shifted = {prem_q, qsh_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_mag_q};

  assign q_fix = q_sign_q ? -qsh_q : qsh_q;
  assign r_fix = (r_sign_q && prem_q != '0) ? -prem_q : prem_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves state_d
    // unassigned and a latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = PREP;
      PREP: state_d = (divisor_q == '0) ? FIX : ITER;
      ITER: if (count_q == '0) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
    // Registered from the next state so ready can only rise on leaving FIX
    // or on flush, never part-way through an operation.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: the whole datapath is reset, not just the architectural state,
    // so a mid-operation reset leaves nothing stale behind.
    if (reset) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      b_mag_q    <= '0;
      prem_q     <= '0;
      qsh_q      <= '0;
      q_sign_q   <= 1'b0;
      r_sign_q   <= 1'b0;
      dbz_flag_q <= 1'b0;
      count_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.write_a) dividend_q <= bus.a;
          if (bus.start && !bus.flush) begin
            divisor_q <= bus.b;
            signed_q  <= bus.signed_ope;
          end
        end
        PREP: begin
          qsh_q      <= a_mag;
          b_mag_q    <= b_mag;
          q_sign_q   <= a_neg ^ b_neg;
          r_sign_q   <= a_neg;
          prem_q     <= '0;
          count_q    <= CW'(WIDTH - 1);
          dbz_flag_q <= (divisor_q == '0);
        end
        ITER: begin
          prem_q  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          qsh_q   <= {qsh_q[WIDTH-2:0], ~diff[WIDTH]};
          count_q <= count_q - CW'(1);
        end
        FIX: begin
          if (!bus.flush) begin
            if (dbz_flag_q) begin
              quot_q <= '1;
              rem_q  <= dividend_q;
              dbz_q  <= 1'b1;
            end else begin
              quot_q <= q_fix;
              rem_q  <= r_fix;
              dbz_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;
  assign bus.ready     = ready_q;
endmodule

// File: tb/tb_seq_int_divider.sv
// Bench for seq_int_divider: directed vector table, hand-written abort/reset
// sequences, and random operations against an arithmetic reference model.
module tb_seq_int_divider;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_int_divider_if #(.WIDTH(32)) bus ();
  seq_int_divider #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a, b;
    bit          sgn, same;
    logic [31:0] q, r;
    bit          dz;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 100) begin
      lat++;
      step();
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit same);
    bus.a = a;
    bus.write_a = 1'b1;
    if (!same) begin
      step();
      bus.write_a = 1'b0;
    end
    bus.b = b;
    bus.signed_ope = sgn;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.write_a = 1'b0;
  endtask

  task automatic start_only(input logic [31:0] b, input bit sgn);
    bus.b = b;
    bus.signed_ope = sgn;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Reference: plain arithmetic. Signed case in 64 bits so most-negative / -1
  // simply wraps when truncated back to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                output logic [31:0] q, output logic [31:0] r, output bit dz);
    longint sa, sb, tq, tr;
    if (b == 32'd0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      tq = sa / sb;
      tr = sa % sb;
      q = tq[31:0]; r = tr[31:0]; dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  initial begin
    int lat;
    logic [31:0] ra, rb, eq, er;
    bit rs, edz;
    int mode;

    tbl[0] = '{32'd100,      32'd7,        1'b0, 1'b0, 32'd14,       32'd2,        1'b0, 34};
    tbl[1] = '{32'hFFFFFFF9, 32'd2,        1'b1, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    tbl[2] = '{32'd7,        32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
    tbl[3] = '{32'd5,        32'd0,        1'b0, 1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 2};
    tbl[4] = '{32'd5,        32'd0,        1'b1, 1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 2};
    tbl[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 32'd0,        1'b0, 34};
    tbl[6] = '{32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 34};
    tbl[7] = '{32'd50,       32'd8,        1'b0, 1'b1, 32'd6,        32'd2,        1'b0, 34};
    tbl[8] = '{32'hFFFFFFF9, 32'd0,        1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2};

    bus.a = '0; bus.b = '0; bus.signed_ope = 1'b0;
    bus.write_a = 1'b0; bus.start = 1'b0; bus.flush = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset_ready", bus.ready, 1'b1);
    check("reset_q", bus.quotient, 32'd0);
    check("reset_r", bus.remainder, 32'd0);
    check("reset_dbz", bus.dbz, 1'b0);

    for (int i = 0; i < 9; i++) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].same);
      wait_ready(lat);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_q", i), bus.quotient, tbl[i].q);
      check($sformatf("vec%0d_r", i), bus.remainder, tbl[i].r);
      check($sformatf("vec%0d_dbz", i), bus.dbz, tbl[i].dz);
    end

    // Flush mid-operation keeps the previous result.
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    wait_ready(lat);
    launch(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) step();
    check("flush_busy_ready", bus.ready, 1'b0);
    check("flush_busy_q", bus.quotient, 32'd14);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_ready", bus.ready, 1'b1);
    check("flush_q", bus.quotient, 32'd14);
    check("flush_r", bus.remainder, 32'd2);
    check("flush_dbz", bus.dbz, 1'b0);

    // Dividend survives the flush; strobes while busy are ignored.
    start_only(32'd3, 1'b0);
    repeat (5) step();
    bus.a = 32'd9; bus.write_a = 1'b1;
    bus.b = 32'd5; bus.start = 1'b1;
    step();
    bus.write_a = 1'b0; bus.start = 1'b0;
    wait_ready(lat);
    check("ign_lat", lat, 28);
    check("ign_q", bus.quotient, 32'd333);
    check("ign_r", bus.remainder, 32'd1);
    start_only(32'd1, 1'b0);
    wait_ready(lat);
    check("ign_dividend_kept", bus.quotient, 32'd1000);

    // Reset during ITER clears outputs and the dividend.
    launch(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_ready", bus.ready, 1'b1);
    check("rst_mid_q", bus.quotient, 32'd0);
    check("rst_mid_r", bus.remainder, 32'd0);
    check("rst_mid_dbz", bus.dbz, 1'b0);
    start_only(32'd0, 1'b0);
    wait_ready(lat);
    check("rst_dbz_lat", lat, 2);
    check("rst_dividend_cleared", bus.remainder, 32'd0);
    check("rst_dbz_flag", bus.dbz, 1'b1);

    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      rs = $urandom_range(0, 1);
      if (mode == 0) rb = 32'd0;
      else if (mode == 1) rb = $urandom_range(1, 20);
      else if (mode == 2) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (mode == 3) rb = rb >> $urandom_range(1, 31);
      model(ra, rb, rs, eq, er, edz);
      launch(ra, rb, rs, bit'($urandom_range(0, 1)));
      wait_ready(lat);
      check($sformatf("rnd%0d_lat", n), lat, (rb == 32'd0) ? 2 : 34);
      check($sformatf("rnd%0d_q a=%h b=%h s=%0d", n, ra, rb, rs), bus.quotient, eq);
      check($sformatf("rnd%0d_r a=%h b=%h s=%0d", n, ra, rb, rs), bus.remainder, er);
      check($sformatf("rnd%0d_dbz", n), bus.dbz, edz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_int_divider.md
Name: seq_int_divider

Overview:
- Sequential radix-2 restoring integer divider. It is the responder side of the CPU multicycle ALU's integer-divide handshake (write_a / start / ready / flush).
- Handles signed and unsigned operands. Produces quotient and remainder together.
- Replaces the legacy memory-mapped-era divider. Fixed latency; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a  in  WIDTH  dividend, captured on write_a
- b  in  WIDTH  divisor, captured on start
- signed_ope  in  1  1 = two's-complement operands, 0 = unsigned; captured on start
- write_a  in  1  one-cycle strobe, latch a into dividend register
- start  in  1  one-cycle strobe, latch b/signed_ope and begin division
- flush  in  1  abort in-flight operation
- quotient  out  WIDTH  registered quotient of last completed operation
- remainder  out  WIDTH  registered remainder of last completed operation
- dbz  out  1  last completed operation had divisor zero
- ready  out  1  1 = idle and results valid; 0 = busy

Behaviour:
- Clock and reset: clock clk; reset reset is synchronous, active-high.
- Reset values: ready=1, quotient=0, remainder=0, dbz=0, dividend register=0, state=IDLE, iteration counter=0.
- States: IDLE, PREP, ITER, FIX.
- IDLE:
  - write_a=1 latches a.
  - start=1 latches b and signed_ope, then goes to PREP; ready<=0 on the same edge.
  - write_a and start in the same cycle: the port value of a is latched and used for this operation.
- PREP (1 cycle):
  - Compute operand magnitudes (negate if signed_ope and MSB set).
  - Record quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
  - Clear partial remainder; counter<=WIDTH-1.
  - If b==0, go directly to FIX with the dbz flag set.
  - Otherwise go to ITER.
- ITER (WIDTH cycles, one quotient bit per cycle, MSB first):
  - Shift partial remainder left, bringing in the next dividend bit.
  - Trial subtract divisor magnitude in WIDTH+1 bits; if non-negative, keep the difference and set the quotient bit to 1, else restore and set it to 0.
  - Counter decrements; at 0, go to FIX.
- FIX (1 cycle):
  - Apply sign correction: negate quotient if quotient sign=1; negate remainder if remainder sign=1 and remainder magnitude≠0.
  - Register quotient, remainder, dbz; ready<=1; go to IDLE.
- Latency (normal): start sampled on edge N → ready low after edge N, ready high after edge N+WIDTH+2 (34 cycles low for WIDTH=32). Results are valid in the same cycle ready rises.
- Latency (divide by zero): ready high after edge N+2.
- Divide by zero, signed or unsigned: quotient=all ones, remainder=dividend as written (raw, no sign processing), dbz=1.
- Signed overflow (most-negative / -1): quotient=most-negative value, remainder=0, dbz=0. This falls out of the magnitude path with no special case.
- Outputs hold the last completed result until the next FIX. They do not change during PREP/ITER.
- start or write_a while busy (PREP/ITER/FIX): ignored. Neither dividend nor operation is disturbed.
- flush=1 in any state: return to IDLE on that edge, ready<=1. quotient, remainder and dbz keep their previous completed values.
  - flush has priority over start in the same cycle: start is dropped.
  - flush does not clear the latched dividend.
- reset mid-operation: all reset values apply on that edge, including dividend=0 and outputs=0.
- The initiator detects completion by the 0→1 edge of ready. ready must never glitch high during an operation.

Test Plan:
- Unsigned: write_a a=100, next cycle start b=7 signed_ope=0 → ready low exactly 34 cycles, then quotient=14, remainder=2, dbz=0.
- Signed: a=0xFFFFFFF9 (-7), b=2, signed_ope=1 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Repeat with a=7, b=0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: a=5, b=0 (signed and unsigned runs) → ready low 2 cycles, quotient=0xFFFFFFFF, remainder=5, dbz=1.
- Overflow and extremes:
  - signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
  - unsigned 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0.
- Abort and ignored strobes:
  - After the 100/7 result, start 1000/3; assert flush 10 cycles in → ready=1 next cycle, quotient still 14, remainder still 2.
  - Fresh start 1000/3, with start and write_a (a=9) pulsed again mid-operation → ignored; result quotient=333, remainder=1.
- Reset and same-cycle strobes:
  - Assert reset at ITER cycle 5 → ready=1, quotient=0, remainder=0, dbz=0 on the next cycle.
  - write_a and start together with a=50, b=8 → quotient=6, remainder=2.
